// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels four byte requesters into one UART transmitter.
// Define UART_ARB_HEADER_EN to send a header byte {6'b101000, grant_id} ahead of each payload byte.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [7:0]  uart_writedata,
    output logic        uart_enable,
    input  logic        uart_done,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
`ifdef UART_ARB_HEADER_EN
        , S_HDR = 2'd3
`endif
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_ack, w_ack_next;
    logic [7:0]  r_wdata, w_wdata_next;
    logic        r_enable, w_enable_next;
    logic        r_busy;
    logic [1:0]  r_grant, w_grant_next;
    logic [1:0]  r_last, w_last_next;
    logic        r_terr, w_terr_next;
    logic [15:0] r_count, w_count_next;
    logic [7:0]  r_byte, w_byte_next;
    logic [1:0]  w_pick;
`ifdef UART_ARB_HEADER_EN
    logic        r_hdr, w_hdr_next;
`endif

    // First requester with req high, searching upward from last+1 with wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req_v[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign w_pick = rr_pick(req, r_last);

    always_comb begin
        // NOTE: every value written here gets a default first, so no latch can be inferred.
        w_state_next  = r_state;
        w_ack_next    = 4'd0;
        w_wdata_next  = r_wdata;
        w_enable_next = 1'b0;
        w_grant_next  = r_grant;
        w_last_next   = r_last;
        w_terr_next   = 1'b0;
        w_count_next  = r_count;
        w_byte_next   = r_byte;
`ifdef UART_ARB_HEADER_EN
        w_hdr_next    = r_hdr;
`endif
        case (r_state)
            S_IDLE: begin
                if (req != 4'd0) begin
                    w_grant_next = w_pick;
                    w_byte_next  = req_data[{w_pick, 3'b000} +: 8];
                    w_ack_next   = 4'b0001 << w_pick;
                    w_count_next = 16'd0;
`ifdef UART_ARB_HEADER_EN
                    w_state_next = S_HDR;
`else
                    w_state_next = S_SEND;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            S_HDR: begin
                w_wdata_next  = {6'b101000, r_grant};
                w_enable_next = 1'b1;
                w_hdr_next    = 1'b1;
                w_state_next  = S_WAIT;
            end
`endif
            S_SEND: begin
                w_wdata_next  = r_byte;
                w_enable_next = 1'b1;
`ifdef UART_ARB_HEADER_EN
                w_hdr_next    = 1'b0;
`endif
                w_state_next  = S_WAIT;
            end
            S_WAIT: begin
                w_count_next = r_count + 16'd1;
                // A done arriving in the expiry cycle still wins over the timeout.
                if (uart_done) begin
`ifdef UART_ARB_HEADER_EN
                    if (r_hdr) begin
                        w_count_next = 16'd0;
                        w_state_next = S_SEND;
                    end else begin
                        w_last_next  = r_grant;
                        w_state_next = S_IDLE;
                    end
`else
                    w_last_next  = r_grant;
                    w_state_next = S_IDLE;
`endif
                end else if (r_count + 16'd1 == TIMEOUT_CYCLES) begin
                    w_terr_next  = 1'b1;
                    w_last_next  = r_grant;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ack    <= 4'd0;
            r_wdata  <= 8'd0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_grant  <= 2'd0;
            r_last   <= 2'd3;
            r_terr   <= 1'b0;
            r_count  <= 16'd0;
            r_byte   <= 8'd0;
`ifdef UART_ARB_HEADER_EN
            r_hdr    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_ack    <= w_ack_next;
            r_wdata  <= w_wdata_next;
            r_enable <= w_enable_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_grant  <= w_grant_next;
            r_last   <= w_last_next;
            r_terr   <= w_terr_next;
            r_count  <= w_count_next;
            r_byte   <= w_byte_next;
`ifdef UART_ARB_HEADER_EN
            r_hdr    <= w_hdr_next;
`endif
        end
    end

    assign ack            = r_ack;
    assign uart_writedata = r_wdata;
    assign uart_enable    = r_enable;
    assign busy           = r_busy;
    assign grant_id       = r_grant;
    assign timeout_err    = r_terr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected UART bytes are queued when requests are driven
// and popped on every uart_enable. Follows UART_ARB_HEADER_EN if defined for the build.
module tb_uart_tx_arbiter;

    localparam logic [15:0] TO = 16'd16;
`ifdef UART_ARB_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] grant;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  uart_writedata;
    logic        uart_enable;
    logic        uart_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .ack            (ack),
        .uart_writedata (uart_writedata),
        .uart_enable    (uart_enable),
        .uart_done      (uart_done),
        .busy           (busy),
        .grant_id       (grant_id),
        .timeout_err    (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         last_en = -100;
    int         done_delay = -1;
    int         done_cnt   = 0;
    int         terr_cnt   = 0;
    int         ack_cnt[4];
    int         pend[4];
    logic [7:0] nxt[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue the header (header builds) and the payload, unless a header timeout aborts the payload.
    task automatic expect_byte(input logic [1:0] g, input logic [7:0] d, input bit hdr_aborts);
        exp_t e;
        if (HDR_EN) begin
            e.data = {6'b101000, g};
            e.grant = g;
            sb.push_back(e);
        end
        if (!(HDR_EN && hdr_aborts)) begin
            e.data = d;
            e.grant = g;
            sb.push_back(e);
        end
    endtask

    task automatic clear_stats();
        terr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ack_cnt[i] = 0;
            pend[i] = 0;
        end
    endtask

    // One clock: UART model, output monitor, and requester reaction to ack.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        uart_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) uart_done = 1'b1;
        end
        if (uart_enable) begin
            if (last_en >= 0) check("en_gap", 32'(cyc - last_en >= 3), 1);
            last_en = cyc;
            if (sb.size() == 0) begin
                check("en_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wdata", uart_writedata, e.data);
                check("grant", grant_id, e.grant);
            end
            if (done_delay > 0) done_cnt = done_delay;
        end
        if (timeout_err) begin
            terr_cnt++;
            check("terr_delay", 32'(cyc - last_en), 32'(TO));
            check("terr_busy", busy, 0);
        end
        if (ack != 4'd0) begin
            check("ack_onehot", $countones(ack), 1);
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    ack_cnt[i]++;
                    if (pend[i] > 0) begin
                        pend[i]--;
                        req_data[8*i +: 8] = nxt[i];
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (sb.size() == 0 && !busy && req == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", ok, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ack", ack, 0);
        check("rst_en", uart_enable, 0);
        check("rst_wdata", uart_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_terr", timeout_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        done_cnt = 0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("post_rst_ack", ack, 0);
        check("post_rst_en", uart_enable, 0);
    endtask

    initial begin
        reset = 1'b1;
        req = 4'd0;
        req_data = 32'd0;
        uart_done = 1'b0;
        clear_stats();

        // Reset values, then a single requester with a late done.
        tick();
        do_reset();
        tick();
        clear_stats();
        done_delay = 10;
        req_data = 32'h1155_2233;
        req = 4'b0100;
        expect_byte(2'd2, 8'h55, 1'b0);
        drain(100);
        check("t2_ack0", ack_cnt[0], 0);
        check("t2_ack1", ack_cnt[1], 0);
        check("t2_ack2", ack_cnt[2], 1);
        check("t2_ack3", ack_cnt[3], 0);
        check("t2_grant", grant_id, 2);
        check("t2_busy", busy, 0);
        check("t2_terr", terr_cnt, 0);

        // Fairness from reset: all four pending, requester 0 has a second byte.
        do_reset();
        clear_stats();
        done_delay = 3;
        req_data = 32'h1312_1110;
        pend[0] = 1;
        nxt[0] = 8'h20;
        req = 4'b1111;
        expect_byte(2'd0, 8'h10, 1'b0);
        expect_byte(2'd1, 8'h11, 1'b0);
        expect_byte(2'd2, 8'h12, 1'b0);
        expect_byte(2'd3, 8'h13, 1'b0);
        expect_byte(2'd0, 8'h20, 1'b0);
        drain(200);
        check("t3_ack0", ack_cnt[0], 2);
        check("t3_ack3", ack_cnt[3], 1);

        // Timeout on requester 1, then requester 2 completes normally.
        clear_stats();
        done_delay = -1;
        req_data = 32'h0032_3100;
        req = 4'b0110;
        expect_byte(2'd1, 8'h31, 1'b1);
        expect_byte(2'd2, 8'h32, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (terr_cnt == 1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t4_terr_seen", seen, 1);
        end
        done_delay = 5;
        drain(100);
        check("t4_ack1", ack_cnt[1], 1);
        check("t4_ack2", ack_cnt[2], 1);
        check("t4_terr_cnt", terr_cnt, 1);
        check("t4_grant", grant_id, 2);

        // Done in the expiry cycle counts as success.
        clear_stats();
        done_delay = 32'(TO) - 1;
        req_data = 32'hC300_0000;
        req = 4'b1000;
        expect_byte(2'd3, 8'hC3, 1'b0);
        drain(100);
        check("t5_terr_cnt", terr_cnt, 0);
        check("t5_ack3", ack_cnt[3], 1);

        // Done one cycle past expiry: timeout, and the late done lands in IDLE and is ignored.
        clear_stats();
        done_delay = 32'(TO);
        req_data = 32'h0000_0077;
        req = 4'b0001;
        expect_byte(2'd0, 8'h77, 1'b1);
        drain(100);
        check("t5b_terr_cnt", terr_cnt, 1);
        tick();
        tick();
        check("t5b_idle_busy", busy, 0);
        check("t5b_idle_en", uart_enable, 0);

        // Reset in the middle of WAIT, then a fresh grant to requester 0.
        clear_stats();
        done_delay = -1;
        req_data = 32'h0000_6600;
        req = 4'b0010;
        expect_byte(2'd1, 8'h66, 1'b1);
        begin
            bit sent;
            sent = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (sb.size() == 0) begin
                    sent = 1'b1;
                    break;
                end
            end
            check("t6_sent", sent, 1);
        end
        repeat (3) tick();
        check("t6_busy_before_rst", busy, 1);
        do_reset();
        clear_stats();
        done_delay = 2;
        req_data = 32'h0000_0099;
        req = 4'b0001;
        expect_byte(2'd0, 8'h99, 1'b0);
        drain(100);
        check("t6_grant", grant_id, 0);
        check("t6_ack0", ack_cnt[0], 1);
        check("t6_terr", terr_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd60000, max cycles to wait for uart_done after issuing a byte.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester byte-pending flag; held high until the matching ack pulse.
REQ-005 req_data  input  32  requester i byte at bits [8i+7:8i]; stable while req[i]=1.
REQ-006 ack  output  4  one-cycle pulse: requester's byte latched; requester may drop req or present the next byte.
REQ-007 uart_writedata  output  8  byte to the UART transmitter.
REQ-008 uart_enable  output  1  one-cycle start strobe to the UART transmitter.
REQ-009 uart_done  input  1  one-cycle completion pulse from the UART transmitter.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 grant_id  output  2  index of the requester currently being served; holds last value in IDLE.
REQ-012 timeout_err  output  1  one-cycle pulse when TIMEOUT_CYCLES expires without uart_done.

Function
REQ-013 FSM states: IDLE, HDR, SEND, WAIT; all outputs registered.
REQ-014 IDLE: when req!=0, select one requester round-robin, starting at (last_grant+1) mod 4 and searching upward with wrap.
REQ-015 On selection: latch the byte, set grant_id, pulse ack[grant] for exactly one cycle, clear the timeout counter, go to HDR (macro defined) or SEND.
REQ-016 SEND: drive uart_writedata with the latched byte, pulse uart_enable for one cycle, go to WAIT next cycle.
REQ-017 uart_writedata holds its value from the SEND cycle until the next SEND or HDR cycle.
REQ-018 WAIT: 16-bit counter increments each cycle; uart_done=1 ends the wait (payload byte -> IDLE; header byte -> SEND).
REQ-019 WAIT: counter reaching TIMEOUT_CYCLES with no uart_done -> pulse timeout_err, go to IDLE; the byte counts as served.
REQ-020 uart_done in the same cycle as timeout expiry is treated as success; no timeout_err.
REQ-021 last_grant updates to grant_id only on return to IDLE; requesters with req low are skipped.
REQ-022 At most one ack bit high in any cycle; no ack outside the selection cycle.
REQ-023 uart_done outside WAIT is ignored.
REQ-024 req changes after selection do not affect the byte in flight.
REQ-025 Minimum spacing between uart_enable pulses: 3 cycles; IDLE lasts at least one cycle between bytes.
REQ-026 Fairness: with all four req held high, grants follow 0,1,2,3,0,... from reset.

Reset
REQ-027 Reset asserted, including mid-transfer: state=IDLE, ack=0, uart_enable=0, uart_writedata=0, busy=0, grant_id=0, timeout_err=0, counter=0, last_grant=3 (first search starts at 0).
REQ-028 No ack or uart_enable pulse in the first cycle after reset deasserts.

Configuration
REQ-029 Macro UART_ARB_HEADER_EN compiled in: each payload byte is preceded by header byte {6'b101000, grant_id}.
REQ-030 Header path: HDR drives the header onto uart_writedata, pulses uart_enable, and enters WAIT with the header flag set.
REQ-031 Header completion (uart_done): clear the counter, go to SEND for the payload.
REQ-032 Header timeout: abort the payload, pulse timeout_err, go to IDLE.
REQ-033 Macro absent: HDR state and header logic are not compiled; one UART byte per grant.

Verification
REQ-034 req=4'b0100, byte2=8'h55, uart_done 20 cycles after uart_enable -> ack=4'b0100 once, uart_writedata=8'h55, grant_id=2, busy drops after done.
REQ-035 req=4'b1111 held, four bytes served -> grant order 0,1,2,3; next grant 0.
REQ-036 uart_done never returned, TIMEOUT_CYCLES=16 -> timeout_err pulse 16 cycles into WAIT, then IDLE; next requester is served.
REQ-037 Reset asserted in WAIT -> all outputs at reset values same cycle; after release, req=4'b0001 -> grant 0.
REQ-038 UART_ARB_HEADER_EN defined, req=4'b1000, byte=8'hC3 -> enable pulses with 8'hA3 then 8'hC3; single ack.
REQ-039 uart_done and timeout expiry in the same cycle -> no timeout_err; normal completion.
